// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with a multi-cycle sequencer for mult/div.
// Provides stall/busy/done handshakes and a HI/LO write strobe.
module alu_ctrl_seq #(
    parameter int CTRL_W  = 4,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic [5:0]        func,
    input  logic [1:0]        alu_op,
    input  logic              flush,
    output logic [CTRL_W-1:0] alu_control,
    output logic              ctrl_valid,
    output logic              illegal,
    output logic              busy,
    output logic              stall,
    output logic              done,
    output logic              hilo_we
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Packed decode result: {illegal, is_mul, is_div, code[3:0]}
    function automatic logic [6:0] decode_fn(input logic [1:0] op, input logic [5:0] fn);
        logic [6:0] res;
        case (op)
            2'b00: res = {3'b000, 4'b0010};
            2'b01: res = {3'b000, 4'b0011};
            2'b10: begin
                case (fn)
                    6'b100000: res = {3'b000, 4'b0010};
                    6'b100010: res = {3'b000, 4'b0011};
                    6'b100100: res = {3'b000, 4'b0000};
                    6'b100101: res = {3'b000, 4'b0001};
                    6'b100110: res = {3'b000, 4'b1101};
                    6'b100111: res = {3'b000, 4'b1100};
                    6'b101010: res = {3'b000, 4'b0111};
                    6'b010000: res = {3'b000, 4'b1000};
                    6'b010010: res = {3'b000, 4'b1001};
                    6'b100001: res = {3'b010, 4'b0100};
                    6'b011010: res = {3'b001, 4'b0101};
                    default:   res = {3'b100, 4'b1111};
                endcase
            end
            default: res = {3'b100, 4'b1111};
        endcase
        return res;
    endfunction

    logic [1:0]        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CTRL_W-1:0] alu_control_r;
    logic              ctrl_valid_r;
    logic              illegal_r;
    logic              busy_r;
    logic              done_r;

    logic [6:0]        dec_s;
    logic              dec_illegal_s;
    logic              dec_mul_s;
    logic              dec_div_s;
    logic [3:0]        dec_code_s;
    logic              accept_s;
    logic [1:0]        state_nxt_s;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic              done_nxt_s;

    assign dec_s         = decode_fn(alu_op, func);
    assign dec_illegal_s = dec_s[6];
    assign dec_mul_s     = dec_s[5];
    assign dec_div_s     = dec_s[4];
    assign dec_code_s    = dec_s[3:0];
    assign accept_s      = issue && (state_r != ST_RUN);

    // Next-state, countdown and completion logic
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (issue && dec_mul_s) begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = CNT_W'(MUL_LAT - 1);
                end else if (issue && dec_div_s) begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = CNT_W'(DIV_LAT - 1);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // flush beats completion, so an aborted op never strobes HI/LO
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = ST_DONE;
                    done_nxt_s  = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            alu_control_r <= {CTRL_W{1'b0}};
            ctrl_valid_r  <= 1'b0;
            illegal_r     <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            ctrl_valid_r <= accept_s;
            illegal_r    <= accept_s && dec_illegal_s;
            busy_r       <= (state_nxt_s == ST_RUN);
            done_r       <= done_nxt_s;
            if (accept_s) begin
                alu_control_r <= CTRL_W'(dec_code_s);
            end
        end
    end

    assign alu_control = alu_control_r;
    assign ctrl_valid  = ctrl_valid_r;
    assign illegal     = illegal_r;
    assign busy        = busy_r;
    assign stall       = busy_r;
    assign done        = done_r;
    assign hilo_we     = done_r;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed self-checking bench for alu_ctrl_seq (MUL_LAT=4, DIV_LAT=32).
module tb_alu_ctrl_seq;

    logic       clk;
    logic       rst;
    logic       issue;
    logic [5:0] func;
    logic [1:0] alu_op;
    logic       flush;
    logic [3:0] alu_control;
    logic       ctrl_valid;
    logic       illegal;
    logic       busy;
    logic       stall;
    logic       done;
    logic       hilo_we;

    int checks;
    int failures;

    alu_ctrl_seq #(
        .CTRL_W (4),
        .MUL_LAT(4),
        .DIV_LAT(32),
        .CNT_W  (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .issue      (issue),
        .func       (func),
        .alu_op     (alu_op),
        .flush      (flush),
        .alu_control(alu_control),
        .ctrl_valid (ctrl_valid),
        .illegal    (illegal),
        .busy       (busy),
        .stall      (stall),
        .done       (done),
        .hilo_we    (hilo_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkc(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%04b expected=%04b", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk1({tag, "_valid"}, ctrl_valid, 1'b0);
        chk1({tag, "_illegal"}, illegal, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_stall"}, stall, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_hilo"}, hilo_we, 1'b0);
    endtask

    // Single-cycle decode table: {alu_op, func, expected code}
    logic [1:0] tab_op   [10] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    logic [5:0] tab_func [10] = '{6'b000000, 6'b111111, 6'b100010, 6'b100100, 6'b100101,
                                  6'b100110, 6'b100111, 6'b101010, 6'b010000, 6'b010010};
    logic [3:0] tab_code [10] = '{4'b0010, 4'b0011, 4'b0011, 4'b0000, 4'b0001,
                                  4'b1101, 4'b1100, 4'b0111, 4'b1000, 4'b1001};

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        issue    = 1'b0;
        func     = 6'b000000;
        alu_op   = 2'b00;
        flush    = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chkc("rst_ctrl", alu_control, 4'b0000);
        chk_quiet("rst");
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("post_rst");

        // Add, single cycle
        alu_op = 2'b10; func = 6'b100000; issue = 1'b1;
        @(negedge clk);
        issue = 1'b0;
        chkc("add_c1_ctrl", alu_control, 4'b0010);
        chk1("add_c1_valid", ctrl_valid, 1'b1);
        chk1("add_c1_illegal", illegal, 1'b0);
        chk1("add_c1_busy", busy, 1'b0);
        @(negedge clk);
        chk1("add_c2_valid", ctrl_valid, 1'b0);
        chkc("add_c2_ctrl", alu_control, 4'b0010);

        // Mult, MUL_LAT=4, with an ignored add issued in cycle 3
        func = 6'b100001; issue = 1'b1;
        @(negedge clk);
        issue = 1'b0;
        chk1("mul_c1_valid", ctrl_valid, 1'b1);
        chkc("mul_c1_ctrl", alu_control, 4'b0100);
        chk1("mul_c1_busy", busy, 1'b1);
        chk1("mul_c1_stall", stall, 1'b1);
        chk1("mul_c1_done", done, 1'b0);
        @(negedge clk);
        chk1("mul_c2_busy", busy, 1'b1);
        chk1("mul_c2_valid", ctrl_valid, 1'b0);
        @(negedge clk);
        chk1("mul_c3_busy", busy, 1'b1);
        chk1("mul_c3_done", done, 1'b0);
        func = 6'b100000; issue = 1'b1;
        @(negedge clk);
        issue = 1'b0;
        chk1("mul_c4_busy", busy, 1'b1);
        chk1("mul_c4_stall", stall, 1'b1);
        chk1("mul_c4_valid", ctrl_valid, 1'b0);
        chkc("mul_c4_ctrl", alu_control, 4'b0100);
        chk1("mul_c4_done", done, 1'b0);
        @(negedge clk);
        chk1("mul_c5_done", done, 1'b1);
        chk1("mul_c5_hilo", hilo_we, 1'b1);
        chk1("mul_c5_busy", busy, 1'b0);
        chk1("mul_c5_stall", stall, 1'b0);
        chk1("mul_c5_valid", ctrl_valid, 1'b0);
        chkc("mul_c5_ctrl", alu_control, 4'b0100);
        @(negedge clk);
        chk1("mul_c6_done", done, 1'b0);
        chk1("mul_c6_hilo", hilo_we, 1'b0);

        // Div, DIV_LAT=32, then add issued in the DONE cycle
        func = 6'b011010; issue = 1'b1;
        @(negedge clk);
        issue = 1'b0;
        chk1("div_c1_valid", ctrl_valid, 1'b1);
        chkc("div_c1_ctrl", alu_control, 4'b0101);
        chk1("div_c1_busy", busy, 1'b1);
        for (int c = 2; c <= 32; c++) begin
            @(negedge clk);
            chk1($sformatf("div_c%0d_busy", c), busy, 1'b1);
            chk1($sformatf("div_c%0d_done", c), done, 1'b0);
        end
        @(negedge clk);
        chk1("div_c33_done", done, 1'b1);
        chk1("div_c33_hilo", hilo_we, 1'b1);
        chk1("div_c33_busy", busy, 1'b0);
        func = 6'b100000; issue = 1'b1;
        @(negedge clk);
        issue = 1'b0;
        chkc("div_c34_ctrl", alu_control, 4'b0010);
        chk1("div_c34_valid", ctrl_valid, 1'b1);
        chk1("div_c34_done", done, 1'b0);
        chk1("div_c34_busy", busy, 1'b0);

        // Illegal func then reserved alu_op, back to back
        alu_op = 2'b10; func = 6'b111111; issue = 1'b1;
        @(negedge clk);
        chkc("ill_func_ctrl", alu_control, 4'b1111);
        chk1("ill_func_illegal", illegal, 1'b1);
        chk1("ill_func_valid", ctrl_valid, 1'b1);
        alu_op = 2'b11; func = 6'b100000;
        @(negedge clk);
        issue = 1'b0;
        chkc("ill_op_ctrl", alu_control, 4'b1111);
        chk1("ill_op_illegal", illegal, 1'b1);
        chk1("ill_op_valid", ctrl_valid, 1'b1);
        @(negedge clk);
        chk1("ill_after_illegal", illegal, 1'b0);
        chk1("ill_after_valid", ctrl_valid, 1'b0);
        chkc("ill_after_ctrl", alu_control, 4'b1111);

        // Back-to-back single-cycle decodes
        issue = 1'b1;
        for (int i = 0; i < 10; i++) begin
            alu_op = tab_op[i];
            func   = tab_func[i];
            @(negedge clk);
            chkc($sformatf("b2b%0d_ctrl", i), alu_control, tab_code[i]);
            chk1($sformatf("b2b%0d_valid", i), ctrl_valid, 1'b1);
            chk1($sformatf("b2b%0d_illegal", i), illegal, 1'b0);
        end
        issue = 1'b0;
        @(negedge clk);
        chk1("b2b_end_valid", ctrl_valid, 1'b0);

        // Flush with a simultaneous issue in RUN
        alu_op = 2'b10; func = 6'b100001; issue = 1'b1;
        @(negedge clk);
        issue = 1'b0;
        chk1("fl_c1_busy", busy, 1'b1);
        @(negedge clk);
        chk1("fl_c2_busy", busy, 1'b1);
        flush = 1'b1; func = 6'b100000; issue = 1'b1;
        @(negedge clk);
        flush = 1'b0; issue = 1'b0;
        chk1("fl_c3_busy", busy, 1'b0);
        chk1("fl_c3_stall", stall, 1'b0);
        chk1("fl_c3_valid", ctrl_valid, 1'b0);
        chkc("fl_c3_ctrl", alu_control, 4'b0100);
        for (int c = 4; c <= 9; c++) begin
            @(negedge clk);
            chk1($sformatf("fl_c%0d_done", c), done, 1'b0);
            chk1($sformatf("fl_c%0d_busy", c), busy, 1'b0);
        end

        // Flush outside RUN does not block an issue
        flush = 1'b1; alu_op = 2'b10; func = 6'b100100; issue = 1'b1;
        @(negedge clk);
        flush = 1'b0; issue = 1'b0;
        chk1("flidle_valid", ctrl_valid, 1'b1);
        chkc("flidle_ctrl", alu_control, 4'b0000);

        // Asynchronous reset mid-RUN of a div
        func = 6'b011010; issue = 1'b1;
        @(negedge clk);
        issue = 1'b0;
        chk1("ar_c1_busy", busy, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chkc("ar_ctrl", alu_control, 4'b0000);
        chk_quiet("ar");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk1($sformatf("ar_post%0d_done", c), done, 1'b0);
            chk1($sformatf("ar_post%0d_busy", c), busy, 1'b0);
        end
        func = 6'b100000; issue = 1'b1;
        @(negedge clk);
        issue = 1'b0;
        chkc("ar_add_ctrl", alu_control, 4'b0010);
        chk1("ar_add_valid", ctrl_valid, 1'b1);
        chk1("ar_add_illegal", illegal, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
